// File: rtl/morph_pkg.sv
// Shared constants and helpers for the streaming morphology filter.
package morph_pkg;

    localparam logic MODE_ERODE  = 1'b0;
    localparam logic MODE_DILATE = 1'b1;

    // Flat index of window bit at row l (0 = oldest line), column c (0 = oldest pixel)
    function automatic int idx(input int l, input int c, input int w);
        return l * w + c;
    endfunction

    // Counter width able to hold 0..n-1, never less than one bit
    function automatic int cntw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/morph_window_reduce.sv
// Masked erode/dilate reduction over a flattened structuring-element window.
module morph_window_reduce
    import morph_pkg::*;
#(
    parameter int N = 9
) (
    input  logic         mode,
    input  logic [N-1:0] data,
    input  logic [N-1:0] element,
    output logic         result
);

    // Erode: every selected bit set; dilate: any selected bit set
    always_comb begin
        if (mode == MODE_DILATE) begin
            result = |(data & element);
        end else begin
            result = &(data | ~element);
        end
    end

endmodule

// File: rtl/morph_stream_filter.sv
// Streaming binary erode/dilate filter with line buffers and border masking.
module morph_stream_filter
    import morph_pkg::*;
#(
    parameter int Width     = 3,
    parameter int Height    = 3,
    parameter int ImgWidth  = 64,
    parameter int ImgHeight = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      mode,
    input  logic [Width*Height-1:0]   element,
    input  logic                      in_valid,
    input  logic                      in_pixel,
    output logic                      out_valid,
    output logic                      out_pixel,
    output logic                      out_last
);

    localparam int N  = Width * Height;
    localparam int CW = cntw(ImgWidth);
    localparam int RW = cntw(ImgHeight);
    localparam int LB = (Height > 1) ? Height - 1 : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(ImgWidth - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(ImgHeight - 1);

    logic [CW-1:0]       col_q;
    logic [RW-1:0]       row_q;
    logic                mode_q;
    logic [N-1:0]        elem_q;
    logic [N-1:0]        win_q;
    logic [ImgWidth-1:0] lb_q [LB];
    logic                out_valid_q;
    logic                out_pixel_q;
    logic                out_last_q;

    logic                frame_start;
    logic                eff_mode;
    logic [N-1:0]        eff_elem;
    logic [Height-1:0]   newcol;
    logic [N-1:0]        win_d;
    logic [N-1:0]        win_masked;
    logic                last_pix;
    logic                reduced;
    logic                unused_win;

    // Build the current window (new column appended) and mask out-of-image bits
    always_comb begin
        frame_start = in_valid && (col_q == '0) && (row_q == '0);
        eff_mode    = frame_start ? mode : mode_q;
        eff_elem    = frame_start ? element : elem_q;
        last_pix    = (col_q == COL_LAST) && (row_q == ROW_LAST);

        newcol = '0;
        for (int l = 0; l < Height - 1; l++) begin
            newcol[l] = lb_q[l][col_q];
        end
        newcol[Height-1] = in_pixel;

        win_d = win_q;
        for (int l = 0; l < Height; l++) begin
            for (int c = 0; c < Width - 1; c++) begin
                win_d[idx(l, c, Width)] = win_q[idx(l, c + 1, Width)];
            end
            win_d[idx(l, Width - 1, Width)] = newcol[l];
        end

        win_masked = win_d;
        for (int l = 0; l < Height; l++) begin
            for (int c = 0; c < Width; c++) begin
                if ((int'(row_q) < Height - 1 - l) || (int'(col_q) < Width - 1 - c)) begin
                    win_masked[idx(l, c, Width)] = ~eff_mode;
                end
            end
        end

        // Oldest column only feeds the shift-out, never the reduction
        unused_win = 1'b0;
        for (int l = 0; l < Height; l++) begin
            unused_win = unused_win ^ win_q[idx(l, 0, Width)];
        end
    end

    morph_window_reduce #(
        .N(N)
    ) u_reduce (
        .mode    (eff_mode),
        .data    (win_masked),
        .element (eff_elem),
        .result  (reduced)
    );

    // Raster counters, frame-start latches, window, line buffers and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            col_q       <= '0;
            row_q       <= '0;
            mode_q      <= MODE_ERODE;
            elem_q      <= '0;
            win_q       <= '0;
            for (int l = 0; l < LB; l++) begin
                lb_q[l] <= '0;
            end
            out_valid_q <= 1'b0;
            out_pixel_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            out_valid_q <= in_valid;
            out_last_q  <= in_valid && last_pix;
            if (in_valid) begin
                out_pixel_q <= reduced;
                win_q       <= win_d;
                for (int l = 0; l < Height - 1; l++) begin
                    lb_q[l][col_q] <= newcol[l+1];
                end
                if (frame_start) begin
                    mode_q <= mode;
                    elem_q <= element;
                end
                if (col_q == COL_LAST) begin
                    col_q <= '0;
                    row_q <= (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
                end else begin
                    col_q <= col_q + 1'b1;
                end
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_pixel = out_pixel_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_morph_stream_filter.sv
// Directed table-driven bench for morph_stream_filter on a 4x4 frame with a 3x3 element.
module tb_morph_stream_filter;

    localparam int W  = 3;
    localparam int H  = 3;
    localparam int IW = 4;
    localparam int IH = 4;

    logic         clk;
    logic         rst;
    logic         mode;
    logic [W*H-1:0] element;
    logic         in_valid;
    logic         in_pixel;
    logic         out_valid;
    logic         out_pixel;
    logic         out_last;

    int n_checks;
    int n_errors;

    typedef struct {
        logic        m;
        logic [8:0]  e;
        logic [15:0] f;
        logic [15:0] x;
        string       name;
    } vec_t;

    vec_t tbl [8];

    morph_stream_filter #(
        .Width     (W),
        .Height    (H),
        .ImgWidth  (IW),
        .ImgHeight (IH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .element   (element),
        .in_valid  (in_valid),
        .in_pixel  (in_pixel),
        .out_valid (out_valid),
        .out_pixel (out_pixel),
        .out_last  (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation still running, required to finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    // One frame of 16 pixels; optional idle gaps and a mid-frame mode/element flip
    task automatic run_frame(input logic m, input logic [8:0] e, input logic [15:0] f,
                             input logic [15:0] x, input bit gaps, input bit flip,
                             input string name);
        int n;
        for (int i = 0; i < 16; i++) begin
            mode     = m;
            element  = e;
            if (flip && i > 0) begin
                mode    = ~m;
                element = '0;
            end
            in_valid = 1'b1;
            in_pixel = f[i];
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            chk($sformatf("%s valid px%0d", name, i), out_valid, 1'b1);
            chk($sformatf("%s pixel px%0d", name, i), out_pixel, x[i]);
            chk($sformatf("%s last px%0d", name, i), out_last, (i == 15));
            if (gaps) begin
                n = $urandom_range(1, 3);
                for (int g = 0; g < n; g++) begin
                    @(posedge clk);
                    #1;
                    chk($sformatf("%s idle valid px%0d g%0d", name, i, g), out_valid, 1'b0);
                    chk($sformatf("%s idle last px%0d g%0d", name, i, g), out_last, 1'b0);
                end
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;

        // Frame bit index = row*4 + col
        tbl[0] = '{1'b0, 9'h1FF, 16'hFFFF, 16'hFFFF, "t1_erode_ones"};
        tbl[1] = '{1'b1, 9'h1FF, 16'h0020, 16'hEEE0, "t2_dilate_point"};
        tbl[2] = '{1'b0, 9'h1FF, 16'hFFFE, 16'hF888, "t3_erode_hole"};
        tbl[3] = '{1'b0, 9'h100, 16'hA5C3, 16'hA5C3, "t4_erode_center"};
        tbl[4] = '{1'b1, 9'h100, 16'h3C96, 16'h3C96, "t4_dilate_center"};
        tbl[5] = '{1'b0, 9'h000, 16'h1234, 16'hFFFF, "empty_erode"};
        tbl[6] = '{1'b1, 9'h000, 16'hFFFF, 16'h0000, "empty_dilate"};
        tbl[7] = '{1'b1, 9'h1FF, 16'h0001, 16'h0777, "dilate_corner"};

        rst      = 1'b1;
        mode     = 1'b0;
        element  = '0;
        in_valid = 1'b0;
        in_pixel = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset out_valid", out_valid, 1'b0);
        chk("reset out_pixel", out_pixel, 1'b0);
        chk("reset out_last", out_last, 1'b0);
        rst = 1'b0;

        // Back-to-back frames from the table
        for (int t = 0; t < 8; t++) begin
            run_frame(tbl[t].m, tbl[t].e, tbl[t].f, tbl[t].x, 1'b0, 1'b0, tbl[t].name);
        end

        // Idle gaps between pixels must not change the result
        run_frame(1'b1, 9'h1FF, 16'h0020, 16'hEEE0, 1'b1, 1'b0, "t5_gaps");

        // Reset in the middle of a frame discards it
        for (int i = 0; i < 6; i++) begin
            mode     = 1'b1;
            element  = 9'h1FF;
            in_valid = 1'b1;
            in_pixel = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        rst      = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("midreset out_valid", out_valid, 1'b0);
        chk("midreset out_pixel", out_pixel, 1'b0);
        chk("midreset out_last", out_last, 1'b0);
        run_frame(1'b0, 9'h1FF, 16'hFFFE, 16'hF888, 1'b0, 1'b0, "t6_after_reset");

        // Mid-frame mode/element flip is ignored; new mode takes effect at next frame start
        run_frame(1'b0, 9'h1FF, 16'hFFFE, 16'hF888, 1'b0, 1'b1, "t6_flip");
        run_frame(1'b1, 9'h1FF, 16'h0020, 16'hEEE0, 1'b0, 1'b0, "t6_next_frame");

        @(posedge clk);
        #1;
        chk("final idle out_valid", out_valid, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/morph_stream_filter.md
Name: morph_stream_filter

Overview:
- Streaming binary morphology filter for raster-scan frames. One pixel enters per valid cycle, one filtered pixel leaves per valid cycle.
- Generalises the single-window erode node:
  - run-time erode/dilate mode;
  - parametrised kernel and frame size;
  - internal line buffers, window register and border handling.
- Sits between the binary pixel source and downstream fitness/compare logic in the genetic morphology pipeline.

Parameters:
Width, 3, structuring-element columns (>=1)
Height, 3, structuring-element rows (>=1)
ImgWidth, 64, pixels per frame line (>=Width)
ImgHeight, 64, lines per frame (>=Height)

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous active-high reset
mode  in  1  0 = erode, 1 = dilate; latched at frame start
element  in  Width*Height  structuring element; bit l*Width+c = window row l (0 = oldest line), column c (0 = oldest pixel); latched at frame start
in_valid  in  1  in_pixel valid this cycle
in_pixel  in  1  binary input pixel, raster order
out_valid  out  1  out_pixel valid
out_pixel  out  1  filtered pixel
out_last  out  1  high with the last output pixel of a frame

Behaviour:
- Reset: col=0, row=0, window and line buffers cleared, latched mode=0, latched element=0, out_valid=0, out_pixel=0, out_last=0.
- Reset mid-frame discards the partial frame. The next valid pixel is (0,0) of a new frame.
- No backpressure: the block is always ready. Cycles with in_valid=0 advance nothing and leave out_valid=0 on the next cycle.
- Frame start (in_valid with col=0, row=0): mode and element are captured and apply from this pixel onward. Changes mid-frame are ignored until the next frame.
- Anchor: the output for input (r,c) uses the window of rows r-Height+1..r and cols c-Width+1..c, with bottom-right = current pixel.
- Latency: out_valid/out_pixel/out_last are registered exactly 1 cycle after the accepting in_valid cycle.
- Line buffers: Height-1 lines of ImgWidth bits, indexed by col. Window column k is formed from in_pixel plus the buffered lines at col.
- Window register: Height x Width bits. It shifts by one column per accepted pixel.
- Border masking: a window bit is out-of-image if r-(Height-1-l)<0 or c-(Width-1-cw)<0. Out-of-image bits take the neutral value: 1 for erode, 0 for dilate. This also masks stale previous-line and previous-frame data.
- Erode: out = AND over all bits of (D | ~E).
- Dilate: out = OR over all bits of (D & E).
- Empty element: erode outputs 1, dilate outputs 0.
- Counters: col wraps at ImgWidth-1 with row++. Row wraps at ImgHeight-1 to 0. out_last is asserted for pixel (ImgHeight-1, ImgWidth-1). Back-to-back frames need no idle cycles.

Decomposition:
- Package morph_pkg holds:
  - MODE_ERODE=0, MODE_DILATE=1;
  - the window index function idx(l,c)=l*Width+c;
  - counter width helper (clog2).
- Sub-module morph_window_reduce: combinational masked erode/dilate reduction over Width*Height bits with mode input. It is the generalised node and is reused elsewhere.

Test Plan:
All tests use ImgWidth=4, ImgHeight=4, 3x3, unless stated.
1. All-ones frame, erode, element all ones -> 16 outputs all 1 (borders neutral); out_last only on the 16th output.
2. All-zero frame except (1,1)=1, dilate, element all ones -> out=1 exactly at rows 1..3, cols 1..3; all else 0.
3. All-ones frame except (0,0)=0, erode, element all ones -> out=0 at rows 0..2, cols 0..2; all else 1.
4. Element = bit 8 only, random frame, each mode -> out_pixel equals in_pixel of the previous valid cycle.
5. Same frames as test 2 with random in_valid gaps (1-3 idle cycles) -> identical output sequence; out_valid exactly 1 cycle after each in_valid.
6. Assert rst after 6 pixels, then a full test-3 frame -> test-3 result. Also, flipping mode mid-frame -> no effect until the next frame's first pixel.
